ctrl_decode_pipe: RTL

- Pipelined successor to the single-cycle control decoder.
- Decodes the D-stage instruction into a control word, registers it into the E stage and tracks E-stage destination and HI/LO state.
- Tracks a multi-cycle MUL/DIV unit and raises a stall for load-use and HI/LO hazards.
- Sits between the IF/ID register and the ID/EX datapath; the hazard logic local to decode lives here.

---
 rtl/ctrl_decode_pipe_pkg.sv | 110 +++++++++++
 rtl/ctrl_decode_pipe_decode_comb.sv | 160 ++++++++++++++++
 rtl/ctrl_decode_pipe.sv | 108 ++++++++++
 3 files changed

// File: rtl/ctrl_decode_pipe_pkg.sv
// Shared decode definitions: MIPS opcode/funct codes, ALU op encodings and the
// control-word layout used between ID and EX.
package ctrl_decode_pipe_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned REG_W   = 5;

  localparam logic [5:0] RTYPE  = 6'h00;
  localparam logic [5:0] REGIMM = 6'h01;
  localparam logic [5:0] IJ     = 6'h02;
  localparam logic [5:0] IJAL   = 6'h03;
  localparam logic [5:0] IBEQ   = 6'h04;
  localparam logic [5:0] IBNE   = 6'h05;
  localparam logic [5:0] IBLEZ  = 6'h06;
  localparam logic [5:0] IBGTZ  = 6'h07;
  localparam logic [5:0] IADDI  = 6'h08;
  localparam logic [5:0] IADDIU = 6'h09;
  localparam logic [5:0] ISLTI  = 6'h0A;
  localparam logic [5:0] ISLTIU = 6'h0B;
  localparam logic [5:0] IANDI  = 6'h0C;
  localparam logic [5:0] IORI   = 6'h0D;
  localparam logic [5:0] IXORI  = 6'h0E;
  localparam logic [5:0] ILUI   = 6'h0F;
  localparam logic [5:0] ILB    = 6'h20;
  localparam logic [5:0] ILH    = 6'h21;
  localparam logic [5:0] ILW    = 6'h23;
  localparam logic [5:0] ILBU   = 6'h24;
  localparam logic [5:0] ILHU   = 6'h25;
  localparam logic [5:0] ISB    = 6'h28;
  localparam logic [5:0] ISH    = 6'h29;
  localparam logic [5:0] ISW    = 6'h2B;

  localparam logic [5:0] RSLL     = 6'h00;
  localparam logic [5:0] RSRL     = 6'h02;
  localparam logic [5:0] RSRA     = 6'h03;
  localparam logic [5:0] RSLLV    = 6'h04;
  localparam logic [5:0] RSRLV    = 6'h06;
  localparam logic [5:0] RSRAV    = 6'h07;
  localparam logic [5:0] RJR      = 6'h08;
  localparam logic [5:0] RJALR    = 6'h09;
  localparam logic [5:0] RSYSCALL = 6'h0C;
  localparam logic [5:0] RMFHI    = 6'h10;
  localparam logic [5:0] RMTHI    = 6'h11;
  localparam logic [5:0] RMFLO    = 6'h12;
  localparam logic [5:0] RMTLO    = 6'h13;
  localparam logic [5:0] RMULT    = 6'h18;
  localparam logic [5:0] RMULTU   = 6'h19;
  localparam logic [5:0] RDIV     = 6'h1A;
  localparam logic [5:0] RDIVU    = 6'h1B;
  localparam logic [5:0] RADD     = 6'h20;
  localparam logic [5:0] RADDU    = 6'h21;
  localparam logic [5:0] RSUB     = 6'h22;
  localparam logic [5:0] RSUBU    = 6'h23;
  localparam logic [5:0] RAND     = 6'h24;
  localparam logic [5:0] ROR      = 6'h25;
  localparam logic [5:0] RXOR     = 6'h26;
  localparam logic [5:0] RNOR     = 6'h27;
  localparam logic [5:0] RSLT     = 6'h2A;
  localparam logic [5:0] RSLTU    = 6'h2B;

  localparam logic [4:0] RI_BLTZ   = 5'h00;
  localparam logic [4:0] RI_BGEZ   = 5'h01;
  localparam logic [4:0] RI_BLTZAL = 5'h10;
  localparam logic [4:0] RI_BGEZAL = 5'h11;

  typedef enum logic [3:0] {
    AluNop  = 4'd0,  AluAdd = 4'd1,  AluSub = 4'd2,  AluSlt = 4'd3,
    AluSltu = 4'd4,  AluAnd = 4'd5,  AluOr  = 4'd6,  AluXor = 4'd7,
    AluNor  = 4'd8,  AluSl  = 4'd9,  AluSrl = 4'd10, AluSra = 4'd11,
    AluMul  = 4'd12, AluDiv = 4'd13
  } alu_op_e;

  typedef enum logic [1:0] {ExtSi = 2'd0, ExtUnsi = 2'd1, ExtLui = 2'd2} ext_e;
  typedef enum logic {RegDstRt = 1'b0, RegDstRd = 1'b1} reg_dst_e;

  // Field positions, LSB up; r31 destination is selected by link, not reg_dst.
  localparam int unsigned ALU_OP_LSB  = 0;
  localparam int unsigned ALU_OP_W    = 4;
  localparam int unsigned REG_DST_BIT = 4;
  localparam int unsigned EXT_LSB     = 5;
  localparam int unsigned EXT_W       = 2;
  localparam int unsigned ALU_SRC_BIT = 7;
  localparam int unsigned ITYPE_BIT   = 8;
  localparam int unsigned MEM_WE_BIT  = 9;
  localparam int unsigned MEM_TO_REG_BIT = 10;
  localparam int unsigned REG_WE_BIT  = 11;
  localparam int unsigned BRANCH_BIT  = 12;
  localparam int unsigned HILO_WR_BIT = 13;
  localparam int unsigned HILO_RD_BIT = 14;
  localparam int unsigned MULDIV_BIT  = 15;
  localparam int unsigned LINK_BIT    = 16;
  localparam int unsigned CTRL_W      = LINK_BIT + 1;

  typedef struct packed {
    logic     link;
    logic     muldiv_start;
    logic     hilo_rd;
    logic     hilo_wr;
    logic     branch;
    logic     reg_we;
    logic     mem_to_reg;
    logic     mem_we;
    logic     itype;
    logic     alu_src;
    ext_e     ext;
    reg_dst_e reg_dst;
    alu_op_e  alu_op;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode_pipe_decode_comb.sv
// Pure combinational instruction decoder: instruction -> control word,
// destination register and hazard-relevant attributes.
module ctrl_decode_comb
  import ctrl_decode_pipe_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  output ctrl_t              ctrl_c,
  output logic [REG_W-1:0]   dst_c,
  output logic               reads_rt_c,
  output logic               is_muldiv_c,
  output logic               is_hilo_c,
  output logic               illegal_c
);

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic             unused_shamt;

  assign op           = instr_i[31:26];
  assign funct        = instr_i[5:0];
  assign rt           = instr_i[20:16];
  assign rd           = instr_i[15:11];
  assign unused_shamt = ^instr_i[10:6];

  always_comb begin
    ctrl_c      = '0;
    reads_rt_c  = 1'b0;
    is_muldiv_c = 1'b0;
    is_hilo_c   = 1'b0;
    illegal_c   = 1'b0;
    dst_c       = '0;

    case (op)
      RTYPE: begin
        reads_rt_c     = 1'b1;
        ctrl_c.reg_dst = RegDstRd;
        ctrl_c.reg_we  = 1'b1;
        case (funct)
          RSLL, RSLLV:     ctrl_c.alu_op = AluSl;
          RSRL, RSRLV:     ctrl_c.alu_op = AluSrl;
          RSRA, RSRAV:     ctrl_c.alu_op = AluSra;
          RADD, RADDU:     ctrl_c.alu_op = AluAdd;
          RSUB, RSUBU:     ctrl_c.alu_op = AluSub;
          RAND:            ctrl_c.alu_op = AluAnd;
          ROR:             ctrl_c.alu_op = AluOr;
          RXOR:            ctrl_c.alu_op = AluXor;
          RNOR:            ctrl_c.alu_op = AluNor;
          RSLT:            ctrl_c.alu_op = AluSlt;
          RSLTU:           ctrl_c.alu_op = AluSltu;
          RJR: begin
            ctrl_c.reg_dst = RegDstRt;
            ctrl_c.reg_we  = 1'b0;
            ctrl_c.branch  = 1'b1;
          end
          RJALR: begin
            ctrl_c.branch = 1'b1;
            ctrl_c.link   = 1'b1;
          end
          RSYSCALL:        ctrl_c = '0;
          RMFHI, RMFLO: begin
            ctrl_c.hilo_rd = 1'b1;
            is_hilo_c      = 1'b1;
          end
          RMTHI, RMTLO: begin
            ctrl_c.reg_dst = RegDstRt;
            ctrl_c.reg_we  = 1'b0;
            ctrl_c.hilo_wr = 1'b1;
            is_hilo_c      = 1'b1;
          end
          RMULT, RMULTU, RDIV, RDIVU: begin
            ctrl_c.reg_dst      = RegDstRt;
            ctrl_c.reg_we       = 1'b0;
            ctrl_c.alu_op       = funct[1] ? AluDiv : AluMul;
            ctrl_c.hilo_wr      = 1'b1;
            ctrl_c.muldiv_start = 1'b1;
            is_muldiv_c         = 1'b1;
            is_hilo_c           = 1'b1;
          end
          default: illegal_c = 1'b1;
        endcase
      end
      IADDI, IADDIU, ISLTI, ISLTIU, IANDI, IORI, IXORI, ILUI: begin
        ctrl_c.alu_src = 1'b1;
        ctrl_c.itype   = 1'b1;
        ctrl_c.reg_we  = 1'b1;
        case (op)
          ISLTI:   ctrl_c.alu_op = AluSlt;
          ISLTIU:  ctrl_c.alu_op = AluSltu;
          IANDI:   ctrl_c.alu_op = AluAnd;
          IORI:    ctrl_c.alu_op = AluOr;
          IXORI:   ctrl_c.alu_op = AluXor;
          ILUI:    ctrl_c.alu_op = AluOr;
          default: ctrl_c.alu_op = AluAdd;
        endcase
        if (op == IANDI || op == IORI || op == IXORI) ctrl_c.ext = ExtUnsi;
        else if (op == ILUI)                           ctrl_c.ext = ExtLui;
      end
      ILB, ILH, ILW, ILBU, ILHU: begin
        ctrl_c.alu_op     = AluAdd;
        ctrl_c.alu_src    = 1'b1;
        ctrl_c.itype      = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.reg_we     = 1'b1;
      end
      ISB, ISH, ISW: begin
        reads_rt_c     = 1'b1;
        ctrl_c.alu_op  = AluAdd;
        ctrl_c.alu_src = 1'b1;
        ctrl_c.itype   = 1'b1;
        ctrl_c.mem_we  = 1'b1;
      end
      IBEQ, IBNE: begin
        reads_rt_c    = 1'b1;
        ctrl_c.alu_op = AluSub;
        ctrl_c.itype  = 1'b1;
        ctrl_c.branch = 1'b1;
      end
      IBLEZ, IBGTZ: begin
        ctrl_c.itype  = 1'b1;
        ctrl_c.branch = 1'b1;
      end
      REGIMM: begin
        ctrl_c.itype  = 1'b1;
        ctrl_c.branch = 1'b1;
        case (rt)
          RI_BLTZ, RI_BGEZ: ;
          RI_BLTZAL, RI_BGEZAL: begin
            ctrl_c.link   = 1'b1;
            ctrl_c.reg_we = 1'b1;
          end
          default: illegal_c = 1'b1;
        endcase
      end
      IJ:   ctrl_c.branch = 1'b1;
      IJAL: begin
        ctrl_c.branch = 1'b1;
        ctrl_c.link   = 1'b1;
        ctrl_c.reg_we = 1'b1;
      end
      default: illegal_c = 1'b1;
    endcase

    // An undefined encoding must not leak any partial control into E.
    if (illegal_c) begin
      ctrl_c      = '0;
      reads_rt_c  = 1'b0;
      is_muldiv_c = 1'b0;
      is_hilo_c   = 1'b0;
    end

    if (ctrl_c.reg_we) begin
      if (ctrl_c.reg_dst == RegDstRd) dst_c = rd;
      else if (ctrl_c.link)           dst_c = REG_W'(31);
      else                            dst_c = rt;
    end
  end

endmodule

// File: rtl/ctrl_decode_pipe.sv
// Pipelined decode stage: D->E control register, load-use / HI-LO stall
// generation and MUL/DIV busy tracking.
module ctrl_decode_pipe
  import ctrl_decode_pipe_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic               valid_d,
  input  logic               flush_i,
  output logic               stall_o,
  output logic [CTRL_W-1:0]  ctrl_e,
  output logic               valid_e,
  output logic [REG_W-1:0]   dst_e,
  output logic               illegal_e,
  output logic               muldiv_busy_o
);

  ctrl_t            dec_ctrl;
  logic [REG_W-1:0] dec_dst;
  logic             dec_reads_rt;
  logic             dec_is_muldiv;
  logic             dec_is_hilo;
  logic             dec_illegal;

  ctrl_t            ctrl_e_q, ctrl_e_d;
  logic             valid_e_q, valid_e_d;
  logic [REG_W-1:0] dst_e_q, dst_e_d;
  logic             illegal_e_q, illegal_e_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [REG_W-1:0] rs_d;
  logic [REG_W-1:0] rt_d;
  logic             busy;
  logic             load_use;
  logic             hilo_haz;
  logic             stall;
  logic             load_e;

  assign rs_d = instr_d[25:21];
  assign rt_d = instr_d[20:16];

  ctrl_decode_comb u_dec (
    .instr_i     (instr_d),
    .ctrl_c      (dec_ctrl),
    .dst_c       (dec_dst),
    .reads_rt_c  (dec_reads_rt),
    .is_muldiv_c (dec_is_muldiv),
    .is_hilo_c   (dec_is_hilo),
    .illegal_c   (dec_illegal)
  );

  // Hazard detection and next-state for the E register and busy counter.
  always_comb begin
    busy     = (cnt_q != '0);
    load_use = valid_e_q & ctrl_e_q.mem_to_reg & (dst_e_q != '0) &
               ((dst_e_q == rs_d) | ((dst_e_q == rt_d) & dec_reads_rt));
    hilo_haz = busy & valid_d & dec_is_hilo;
    stall    = (load_use | hilo_haz) & valid_d & ~flush_i;
    load_e   = valid_d & ~flush_i & ~stall;

    ctrl_e_d    = '0;
    valid_e_d   = 1'b0;
    dst_e_d     = '0;
    illegal_e_d = 1'b0;
    if (load_e) begin
      ctrl_e_d    = dec_ctrl;
      valid_e_d   = 1'b1;
      dst_e_d     = dec_dst;
      illegal_e_d = dec_illegal;
    end

    // Issued ops run to completion; only a fresh issue reloads the count.
    cnt_d = cnt_q;
    if (load_e && dec_is_muldiv)
      cnt_d = (dec_ctrl.alu_op == AluDiv) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    else if (busy)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_e_q    <= '0;
      valid_e_q   <= 1'b0;
      dst_e_q     <= '0;
      illegal_e_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ctrl_e_q    <= ctrl_e_d;
      valid_e_q   <= valid_e_d;
      dst_e_q     <= dst_e_d;
      illegal_e_q <= illegal_e_d;
      cnt_q       <= cnt_d;
    end
  end

  assign stall_o       = stall;
  assign ctrl_e        = ctrl_e_q;
  assign valid_e       = valid_e_q;
  assign dst_e         = dst_e_q;
  assign illegal_e     = illegal_e_q;
  assign muldiv_busy_o = busy;

endmodule
